// File: rtl/gpio_input_irq.sv
// gpio_input_irq: synchronizes raw GPIO pins, optionally debounces them,
// detects rising/falling level transitions and latches them as sticky
// per-pin pending flags that drive a maskable interrupt request.
//
// Build option: define GPIO_INPUT_IRQ_DEBOUNCE_EN to insert a per-pin
// debounce filter (DEBOUNCE_CYCLES consecutive differing samples are needed
// before o_level follows the pin). Without it, o_level is simply a third
// register stage behind the synchronizer and DEBOUNCE_CYCLES is ignored.
module gpio_input_irq #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_irq_mask,
  input  logic [WIDTH-1:0] i_ack,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_irq
);

  // Reject out-of-range filter lengths at elaboration time.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("gpio_input_irq: DEBOUNCE_CYCLES must be in 2..255");
  end

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_pins;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;

  // Two-flop synchronizer bringing the asynchronous pins into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_meta <= '0;
      sync_pins <= '0;
    end else begin
      sync_meta <= i_pins;
      sync_pins <= sync_meta;
    end
  end

`ifdef GPIO_INPUT_IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt [WIDTH];

  // Debounce filter: a pin's level is accepted only after it has differed
  // from the stable level for DEBOUNCE_CYCLES consecutive samples; any
  // agreeing sample restarts the count, so the counter never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_pins[i] == o_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_MAX) begin
          o_level[i] <= sync_pins[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  // Without the filter the stable level is just one more register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level <= '0;
    end else begin
      o_level <= sync_pins;
    end
  end
`endif

  // Edge detection compares the stable level with its previous value; the
  // enables are applied at this point so they only affect current transitions.
  always_comb begin
    rise_evt = o_level & ~level_d & i_rise_en;
    fall_evt = ~o_level & level_d & i_fall_en;
  end

  // Sticky pending flags: write-1 acknowledge clears, but a new event in the
  // same cycle wins. level_d resets to 0 so a pin held high through reset
  // still yields one rise event once the filter accepts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_d   <= '0;
      o_pending <= '0;
    end else begin
      level_d   <= o_level;
      o_pending <= (o_pending & ~i_ack) | rise_evt | fall_evt;
    end
  end

  // Interrupt request is purely combinational so unmasking takes effect at once.
  always_comb begin
    o_irq = |(o_pending & i_irq_mask);
  end

endmodule

// File: tb/tb_gpio_input_irq.sv
// tb_gpio_input_irq: directed, self-checking bench for gpio_input_irq
// (WIDTH=8, DEBOUNCE_CYCLES=4). Latencies adapt to whether the debounce
// filter is built (GPIO_INPUT_IRQ_DEBOUNCE_EN).
module tb_gpio_input_irq;

`ifdef GPIO_INPUT_IRQ_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] pins;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic [7:0] irq_mask;
  logic [7:0] ack;
  logic [7:0] level;
  logic [7:0] pending;
  logic       irq;

  int checks;
  int fails;

  gpio_input_irq #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pins     (pins),
    .i_rise_en  (rise_en),
    .i_fall_en  (fall_en),
    .i_irq_mask (irq_mask),
    .i_ack      (ack),
    .o_level    (level),
    .o_pending  (pending),
    .o_irq      (irq)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] re,
                               input logic [7:0] fe, input logic [7:0] m,
                               input logic [7:0] a);
    pins     = p;
    rise_en  = re;
    fall_en  = fe;
    irq_mask = m;
    ack      = a;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    applyStimulus(8'hFF, 8'h01, 8'h00, 8'hFF, 8'h00);
    step(2);
    checkOutput("reset_level",   level,        8'h00);
    checkOutput("reset_pending", pending,      8'h00);
    checkOutput("reset_irq",     {7'b0, irq}, 8'h00);

    // Basic rise on pin0 with exact latency boundaries.
    applyStimulus(8'h00, 8'h01, 8'h00, 8'hFF, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(3);
    pins = 8'h01;
    step(LAT - 1);
    checkOutput("rise_level_early", level, 8'h00);
    step(1);
    checkOutput("rise_level",       level,        8'h01);
    checkOutput("rise_pend_early",  pending,      8'h00);
    checkOutput("rise_irq_early",   {7'b0, irq}, 8'h00);
    step(1);
    checkOutput("rise_pending",     pending,      8'h01);
    checkOutput("rise_irq",         {7'b0, irq}, 8'h01);

    // Acknowledge clears the flag.
    ack = 8'h01;
    step(1);
    ack = 8'h00;
    checkOutput("ack_pending", pending,      8'h00);
    checkOutput("ack_irq",     {7'b0, irq}, 8'h00);

    // Short pulse on pin3.
    applyStimulus(8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00);
`ifdef GPIO_INPUT_IRQ_DEBOUNCE_EN
    pins = 8'h09;
    step(3);
    pins = 8'h01;
    step(8);
    checkOutput("glitch_level",   level,   8'h01);
    checkOutput("glitch_pending", pending, 8'h00);
`else
    pins = 8'h09;
    step(1);
    pins = 8'h01;
    step(LAT - 1);
    checkOutput("glitch_level_hi", level,   8'h09);
    step(1);
    checkOutput("glitch_level_lo", level,   8'h01);
    checkOutput("glitch_pending",  pending, 8'h08);
    step(1);
    checkOutput("glitch_pend_both", pending, 8'h08);
    ack = 8'h08;
    step(1);
    ack = 8'h00;
    checkOutput("glitch_ack", pending, 8'h00);
`endif

    // Ack colliding with a new event on pin2: set wins.
    pins = 8'h05;
    step(LAT + 1);
    checkOutput("pin2_rise_pending", pending, 8'h04);
    pins = 8'h01;
    step(LAT);
    checkOutput("pin2_fall_level", level, 8'h01);
    ack = 8'h04;
    step(1);
    ack = 8'h00;
    checkOutput("collide_pending", pending, 8'h04);
    step(1);
    checkOutput("collide_hold", pending, 8'h04);
    ack = 8'h04;
    step(1);
    ack = 8'h00;
    checkOutput("late_ack_pending", pending,      8'h00);
    checkOutput("late_ack_irq",     {7'b0, irq}, 8'h00);

    // Disabled edges do not flag: pin4 rises with no enables.
    applyStimulus(8'h11, 8'h00, 8'h00, 8'hFF, 8'h00);
    step(LAT + 2);
    checkOutput("noen_level",   level,   8'h11);
    checkOutput("noen_pending", pending, 8'h00);
    pins = 8'h01;
    step(LAT + 2);
    checkOutput("noen_fall_pending", pending, 8'h00);

    // Masking: pin5 rise then fall, mask only gates the interrupt.
    applyStimulus(8'h21, 8'h00, 8'h20, 8'h00, 8'h00);
    step(LAT + 2);
    checkOutput("mask_rise_level", level,   8'h21);
    checkOutput("mask_rise_nopend", pending, 8'h00);
    pins = 8'h01;
    step(LAT + 1);
    checkOutput("mask_fall_pending", pending,      8'h20);
    checkOutput("mask_fall_irq",     {7'b0, irq}, 8'h00);
    irq_mask = 8'h20;
    #1;
    checkOutput("unmask_irq", {7'b0, irq}, 8'h01);
    irq_mask = 8'hDF;
    #1;
    checkOutput("othermask_irq", {7'b0, irq}, 8'h00);
    irq_mask = 8'hFF;

    // Mid-debounce reset on pin1; pin7 held high through reset release.
    applyStimulus(8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00);
    step(2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_level",   level,        8'h00);
    checkOutput("midrst_pending", pending,      8'h00);
    checkOutput("midrst_irq",     {7'b0, irq}, 8'h00);
    step(1);
    pins = 8'h80;
    step(1);
    rst_n = 1'b1;
    step(LAT);
    checkOutput("post_rst_level",   level,   8'h80);
    checkOutput("post_rst_pend_lo", pending, 8'h00);
    step(1);
    checkOutput("post_rst_pending", pending,      8'h80);
    checkOutput("post_rst_irq",     {7'b0, irq}, 8'h01);
    step(8);
    checkOutput("post_rst_settled", pending, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
